// File: rtl/led_seq_monitor.sv
// LED chaser sequence monitor: tracks thermometer fill/drain patterns on q_in,
// flags illegal transitions, counts errors and reports long pauses as stall.
module led_seq_monitor #(
  parameter int HOLD_MAX = 1000,
  parameter int CNT_W    = 8
) (
  input  logic             clk,
  input  logic             rs,
  input  logic [7:0]       q_in,
  input  logic             en,
  output logic [1:0]       mode,
  output logic [3:0]       level,
  output logic             full_p,
  output logic             empty_p,
  output logic             err_p,
  output logic [CNT_W-1:0] err_cnt,
  output logic             stall
);

  localparam int HW = $clog2(HOLD_MAX + 1);
  localparam logic [HW-1:0] HOLD_LIM = HW'(HOLD_MAX);

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    FILL  = 2'b01,
    DRAIN = 2'b10,
    ERROR = 2'b11
  } mode_t;

  mode_t            state_reg, state_next;
  logic [7:0]       q_prev_reg;
  logic [3:0]       level_reg, level_next;
  logic [HW-1:0]    hold_reg, hold_next;
  logic             stall_reg, stall_next;
  logic             full_reg, full_next;
  logic             empty_reg, empty_next;
  logic             err_reg, err_next;
  logic [CNT_W-1:0] err_cnt_reg;

  logic       change;
  logic       eval;
  logic       therm;
  logic       step_up;
  logic       step_dn;
  logic [3:0] k_new;
  logic [6:0] mono;

  // Thermometer iff no lit bit sits above an unlit one.
  generate
    for (genvar gi = 0; gi < 7; gi++) begin : g_mono
      assign mono[gi] = ~q_in[gi+1] | q_in[gi];
    end
  endgenerate

  assign therm = &mono;

  always_comb begin
    k_new = 4'd0;
    for (int i = 0; i < 8; i++) begin
      k_new = k_new + {3'b000, q_in[i]};
    end
  end

  assign change  = (q_in != q_prev_reg);
  assign eval    = en && change;
  assign step_up = therm && (k_new == level_reg + 4'd1);
  assign step_dn = therm && (level_reg != 4'd0) && (k_new == level_reg - 4'd1);

  always_ff @(posedge clk) begin
    if (rs) begin
      state_reg <= IDLE;
    end else if (en) begin
      state_reg <= state_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    if (eval) begin
      case (state_reg)
        IDLE: begin
          if (step_up)      state_next = FILL;
          else if (step_dn) state_next = DRAIN;
          else if (!therm)  state_next = ERROR;
        end
        FILL, DRAIN: begin
          if (step_up)      state_next = FILL;
          else if (step_dn) state_next = DRAIN;
          else              state_next = ERROR;
        end
        ERROR: begin
          if (therm)        state_next = IDLE;
        end
        default:            state_next = IDLE;
      endcase
    end
  end

  // Registered-output values; ERROR resync updates level but never pulses.
  always_comb begin
    level_next = level_reg;
    full_next  = 1'b0;
    empty_next = 1'b0;
    err_next   = 1'b0;
    if (eval) begin
      if (state_reg == ERROR) begin
        if (therm) level_next = k_new;
        else       err_next   = 1'b1;
      end else if (step_up || step_dn) begin
        level_next = k_new;
        full_next  = (k_new == 4'd8);
        empty_next = (k_new == 4'd0);
      end else if (therm && state_reg == IDLE) begin
        level_next = k_new;
      end else begin
        err_next   = 1'b1;
      end
    end
  end

  always_comb begin
    if (change)                 hold_next = '0;
    else if (hold_reg == HOLD_LIM) hold_next = hold_reg;
    else                        hold_next = hold_reg + 1'b1;
    stall_next = (hold_next == HOLD_LIM);
  end

  always_ff @(posedge clk) begin
    if (rs) begin
      q_prev_reg  <= 8'h00;
      level_reg   <= 4'd0;
      hold_reg    <= '0;
      stall_reg   <= 1'b0;
      full_reg    <= 1'b0;
      empty_reg   <= 1'b0;
      err_reg     <= 1'b0;
      err_cnt_reg <= '0;
    end else if (en) begin
      q_prev_reg <= q_in;
      level_reg  <= level_next;
      hold_reg   <= hold_next;
      stall_reg  <= stall_next;
      full_reg   <= full_next;
      empty_reg  <= empty_next;
      err_reg    <= err_next;
      if (err_next && (err_cnt_reg != {CNT_W{1'b1}})) begin
        err_cnt_reg <= err_cnt_reg + 1'b1;
      end
    end else begin
      full_reg  <= 1'b0;
      empty_reg <= 1'b0;
      err_reg   <= 1'b0;
    end
  end

  assign mode    = state_reg;
  assign level   = level_reg;
  assign full_p  = full_reg;
  assign empty_p = empty_reg;
  assign err_p   = err_reg;
  assign err_cnt = err_cnt_reg;
  assign stall   = stall_reg;

endmodule
